oled_spi_sink: RTL

- SPI receiver/decoder for the OLED page-write stream: the display-side end of the 4-wire link (CS, SCLK, SDO, DC) driven by the OLED character-display controller.
- Oversamples the link on the system clock and assembles bytes. Decodes the page/column commands and writes data bytes into an internal 4x128-byte frame buffer, which has a read port.
- Used as a synthesizable display model in simulation and as an on-chip monitor for screen-content checks.

---
 rtl/oled_spi_sink.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/oled_spi_sink.sv
// Display-side end of the OLED 4-wire SPI page-write link: oversampled byte
// receiver, page/column command decoder and a readable page x column frame buffer.
module oled_spi_sink #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_COLS    = 128,
    parameter int NUM_PAGES   = 4,
    localparam int COL_W      = $clog2(NUM_COLS),
    localparam int PAGE_W     = $clog2(NUM_PAGES),
    localparam int ADDR_W     = PAGE_W + COL_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS,
    input  logic              SCLK,
    input  logic              SDO,
    input  logic              DC,
    output logic              BYTE_VALID,
    output logic [7:0]        BYTE_DATA,
    output logic              BYTE_DC,
    input  logic [ADDR_W-1:0] FB_RADDR,
    output logic [7:0]        FB_RDATA,
    output logic [PAGE_W-1:0] CUR_PAGE,
    output logic [COL_W-1:0]  CUR_COL,
    output logic              FRAME_DONE,
    output logic              UNK_CMD,
    output logic [0:0]        DBG_STATE
);

    localparam logic [0:0] CMD_IDLE     = 1'b0;
    localparam logic [0:0] CMD_PAGE_ARG = 1'b1;

    logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdo_sync, dc_sync;
    logic                   cs_s, sclk_s, sdo_s, dc_s;
    logic                   sclk_prev;
    logic                   sclk_rise;
    logic [6:0]             shift_reg;
    logic [2:0]             bit_cnt;
    logic [0:0]             state;
    logic [COL_W-1:0]       col_cmd;
    logic [7:0]             fb [NUM_PAGES*NUM_COLS];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_sync   <= '1;
            sclk_sync <= '1;
            sdo_sync  <= '0;
            dc_sync   <= '0;
            sclk_prev <= 1'b1;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            sdo_sync  <= {sdo_sync[SYNC_STAGES-2:0], SDO};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], DC};
            sclk_prev <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdo_s     = sdo_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev & ~cs_s;

    // BYTE_VALID is a push-only strobe with no ready: the consumer must take
    // BYTE_DATA/BYTE_DC in the strobe cycle; both hold until the next strobe.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            BYTE_VALID <= 1'b0;
            BYTE_DATA  <= '0;
            BYTE_DC    <= 1'b0;
        end else begin
            BYTE_VALID <= sclk_rise && (bit_cnt == 3'd7);
            if (cs_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[5:0], sdo_s};
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) begin
                    BYTE_DATA <= {shift_reg, sdo_s};
                    BYTE_DC   <= dc_s;
                end
            end
        end
    end

    // Column commands: 0x0N loads the low nibble, 0x1N loads bits [6:4].
    always_comb begin
        col_cmd = CUR_COL;
        if (BYTE_DATA[4] == 1'b0) begin
            col_cmd[3:0] = BYTE_DATA[3:0];
        end else begin
            for (int i = 4; i < COL_W && i < 7; i++) begin
                col_cmd[i] = BYTE_DATA[i-4];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= CMD_IDLE;
            CUR_PAGE   <= '0;
            CUR_COL    <= '0;
            FRAME_DONE <= 1'b0;
            UNK_CMD    <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            UNK_CMD    <= 1'b0;
            if (BYTE_VALID) begin
                if (BYTE_DC) begin
                    CUR_COL    <= CUR_COL + 1'b1;
                    FRAME_DONE <= (CUR_PAGE == '1) && (CUR_COL == '1);
                    if (CUR_COL == '1) begin
                        CUR_PAGE <= CUR_PAGE + 1'b1;
                    end
                end else if (state == CMD_PAGE_ARG) begin
                    CUR_PAGE <= BYTE_DATA[PAGE_W-1:0];
                    state    <= CMD_IDLE;
                end else if (BYTE_DATA == 8'h22) begin
                    state <= CMD_PAGE_ARG;
                end else if (BYTE_DATA[7:4] == 4'h0 || BYTE_DATA[7:3] == 5'b00010) begin
                    CUR_COL <= col_cmd;
                end else begin
                    UNK_CMD <= 1'b1;
                end
            end
        end
    end

    assign DBG_STATE = state;

    // Frame buffer holds its contents across reset; read is read-first.
    always_ff @(posedge CLK) begin
        if (BYTE_VALID && BYTE_DC) begin
            fb[{CUR_PAGE, CUR_COL}] <= BYTE_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FB_RDATA <= '0;
        end else begin
            FB_RDATA <= fb[FB_RADDR];
        end
    end

endmodule
